// File: rtl/multicycle_datapath.sv
// Multicycle 8-bit datapath: PC/IR/MDR/R1/R2/ALUOut registers, a 4x8 register
// file, the ALU and N/Z flags. It executes one control word per clock edge.
module multicycle_datapath #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREGS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             PCwrite,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             IRload,
  input  logic             R1Sel,
  input  logic             MDRload,
  input  logic             R1R2Load,
  input  logic             ALU1,
  input  logic [2:0]       ALU2,
  input  logic [2:0]       ALUop,
  input  logic             ALUOutWrite,
  input  logic             RFWrite,
  input  logic             RegIn,
  input  logic             FlagWrite,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  output logic             mem_re,
  output logic [3:0]       instr,
  output logic             N,
  output logic             Z,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] ir_out
);

  localparam int unsigned RIDX_W = $clog2(NREGS);

  logic [WIDTH-1:0]  r_pc;
  logic [WIDTH-1:0]  r_ir;
  logic [WIDTH-1:0]  r_mdr;
  logic [WIDTH-1:0]  r_r1;
  logic [WIDTH-1:0]  r_r2;
  logic [WIDTH-1:0]  r_aluout;
  logic [WIDTH-1:0]  r_rf [NREGS];
  logic              r_n;
  logic              r_z;

  logic [RIDX_W-1:0] w_ra;
  logic [RIDX_W-1:0] w_rb;
  logic [RIDX_W-1:0] w_rd1;
  logic [WIDTH-1:0]  w_rf_wdata;
  logic [WIDTH-1:0]  w_alu_a;
  logic [WIDTH-1:0]  w_alu_b;
  logic [WIDTH-1:0]  w_alu_res;

  // Instruction field decode; ORI forces register 1 for both read and write
  assign w_ra       = r_ir[7:6];
  assign w_rb       = r_ir[5:4];
  assign w_rd1      = R1Sel ? RIDX_W'(1) : w_ra;
  assign w_rf_wdata = RegIn ? r_mdr : r_aluout;
  assign w_alu_a    = ALU1 ? r_r1 : r_pc;

  // ALU B operand select
  always_comb begin
    w_alu_b = '0;
    case (ALU2)
      3'b000:  w_alu_b = r_r2;
      3'b001:  w_alu_b = WIDTH'(1);
      3'b010:  w_alu_b = {{(WIDTH-4){r_ir[7]}}, r_ir[7:4]};
      3'b011:  w_alu_b = {{(WIDTH-5){1'b0}}, r_ir[7:3]};
      3'b100:  w_alu_b = {{(WIDTH-3){1'b0}}, r_ir[5:3]};
      default: w_alu_b = '0;
    endcase
  end

  // ALU operation; shift direction in B[2], amount in B[1:0]
  always_comb begin
    w_alu_res = '0;
    case (ALUop)
      3'b000:  w_alu_res = w_alu_a + w_alu_b;
      3'b001:  w_alu_res = w_alu_a - w_alu_b;
      3'b010:  w_alu_res = w_alu_a | w_alu_b;
      3'b011:  w_alu_res = ~(w_alu_a & w_alu_b);
      3'b100:  w_alu_res = w_alu_b[2] ? (w_alu_a >> w_alu_b[1:0])
                                      : (w_alu_a << w_alu_b[1:0]);
      default: w_alu_res = '0;
    endcase
  end

  // Datapath registers; every load samples pre-edge values
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc     <= '0;
      r_ir     <= '0;
      r_mdr    <= '0;
      r_r1     <= '0;
      r_r2     <= '0;
      r_aluout <= '0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
    end else begin
      if (PCwrite)     r_pc     <= w_alu_res;
      if (IRload)      r_ir     <= mem_rdata;
      if (MDRload)     r_mdr    <= mem_rdata;
      if (ALUOutWrite) r_aluout <= w_alu_res;
      if (R1R2Load) begin
        r_r1 <= r_rf[w_rd1];
        r_r2 <= r_rf[w_rb];
      end
      if (FlagWrite) begin
        r_n <= w_alu_res[WIDTH-1];
        r_z <= (w_alu_res == '0);
      end
    end
  end

  // Register file write; concurrent R1/R2 latch sees the old contents
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rf <= '{default: '0};
    end else if (RFWrite) begin
      r_rf[w_rd1] <= w_rf_wdata;
    end
  end

  assign mem_addr  = IRload ? r_pc : r_r2;
  assign mem_wdata = r_r1;
  assign mem_we    = MemWrite;
  assign mem_re    = MemRead;
  assign instr     = r_ir[3:0];
  assign N         = r_n;
  assign Z         = r_z;
  assign pc_out    = r_pc;
  assign ir_out    = r_ir;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: table of ALU vectors plus
// hand-written fetch, read-before-write, load/store, branch and reset sequences.
module tb_multicycle_datapath;

  typedef struct packed {
    logic       pcwrite;
    logic       memread;
    logic       memwrite;
    logic       irload;
    logic       r1sel;
    logic       mdrload;
    logic       r1r2load;
    logic       alu1;
    logic [2:0] alu2;
    logic [2:0] aluop;
    logic       aluoutwrite;
    logic       rfwrite;
    logic       regin;
    logic       flagwrite;
  } ctrl_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] ir;
    logic [2:0] alu2;
    logic [2:0] aluop;
    logic [7:0] res;
    logic       n;
    logic       z;
    string      name;
  } vec_t;

  logic       clock;
  logic       reset;
  ctrl_t      cw;
  logic [7:0] mem_rdata;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [3:0] instr;
  logic       N;
  logic       Z;
  logic [7:0] pc_out;
  logic [7:0] ir_out;

  logic [7:0] mem [256];
  logic [7:0] pc_m;
  logic [7:0] r0_m;
  int         n_checks;
  int         n_errors;
  vec_t       vecs [13];

  multicycle_datapath dut (
    .clock       (clock),
    .reset       (reset),
    .PCwrite     (cw.pcwrite),
    .MemRead     (cw.memread),
    .MemWrite    (cw.memwrite),
    .IRload      (cw.irload),
    .R1Sel       (cw.r1sel),
    .MDRload     (cw.mdrload),
    .R1R2Load    (cw.r1r2load),
    .ALU1        (cw.alu1),
    .ALU2        (cw.alu2),
    .ALUop       (cw.aluop),
    .ALUOutWrite (cw.aluoutwrite),
    .RFWrite     (cw.rfwrite),
    .RegIn       (cw.regin),
    .FlagWrite   (cw.flagwrite),
    .mem_rdata   (mem_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .instr       (instr),
    .N           (N),
    .Z           (Z),
    .pc_out      (pc_out),
    .ir_out      (ir_out)
  );

  // Asynchronous-read memory model
  assign mem_rdata = mem[mem_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // One clock edge; memory write is committed with pre-edge address/data
  task automatic tick();
    logic       we_q;
    logic [7:0] a_q;
    logic [7:0] d_q;
    we_q = mem_we;
    a_q  = mem_addr;
    d_q  = mem_wdata;
    @(posedge clock);
    if (we_q) mem[a_q] = d_q;
    #1;
  endtask

  task automatic do_reset();
    cw    = '0;
    reset = 1'b1;
    #3;
    reset = 1'b0;
    pc_m  = 8'h00;
    r0_m  = 8'h00;
  endtask

  task automatic set_ir(input logic [7:0] v);
    mem[pc_m]   = v;
    cw          = '0;
    cw.pcwrite  = 1'b1;
    cw.memread  = 1'b1;
    cw.irload   = 1'b1;
    cw.alu2     = 3'b001;
    tick();
    pc_m = pc_m + 8'd1;
  endtask

  // Load a register from memory at the address held in r0
  task automatic load_reg(input logic [1:0] r, input logic [7:0] val);
    set_ir({r, 2'b00, 4'h0});
    cw = '0;
    cw.r1r2load = 1'b1;
    tick();
    mem[r0_m] = val;
    cw = '0;
    cw.memread = 1'b1;
    cw.mdrload = 1'b1;
    tick();
    cw = '0;
    cw.rfwrite = 1'b1;
    cw.regin   = 1'b1;
    tick();
    if (r == 2'd0) r0_m = val;
  endtask

  // Observe a register through R1 -> mem_wdata
  task automatic read_reg(input logic [1:0] r, input logic [7:0] exp, input string name);
    set_ir({r, r, 4'h0});
    cw = '0;
    cw.r1r2load = 1'b1;
    tick();
    chk(name, mem_wdata, exp);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    vecs[0]  = '{8'h70, 8'h90, 8'h20, 3'b000, 3'b000, 8'h00, 1'b0, 1'b1, "add_wrap"};
    vecs[1]  = '{8'h05, 8'h07, 8'h20, 3'b000, 3'b001, 8'hFE, 1'b1, 1'b0, "sub_neg"};
    vecs[2]  = '{8'h80, 8'h00, 8'hFF, 3'b011, 3'b010, 8'h9F, 1'b1, 1'b0, "ori_imm5"};
    vecs[3]  = '{8'hF0, 8'h3C, 8'h20, 3'b000, 3'b011, 8'hCF, 1'b1, 1'b0, "nand"};
    vecs[4]  = '{8'hFF, 8'hFF, 8'h20, 3'b000, 3'b011, 8'h00, 1'b0, 1'b1, "nand_zero"};
    vecs[5]  = '{8'h81, 8'h00, 8'hAB, 3'b100, 3'b100, 8'h40, 1'b0, 1'b0, "shr1"};
    vecs[6]  = '{8'h81, 8'h00, 8'h8B, 3'b100, 3'b100, 8'h02, 1'b0, 1'b0, "shl1"};
    vecs[7]  = '{8'h81, 8'h00, 8'h18, 3'b100, 3'b100, 8'h08, 1'b0, 1'b0, "shl3"};
    vecs[8]  = '{8'hFF, 8'h00, 8'h20, 3'b001, 3'b000, 8'h00, 1'b0, 1'b1, "inc_wrap"};
    vecs[9]  = '{8'h10, 8'h00, 8'hE0, 3'b010, 3'b000, 8'h0E, 1'b0, 1'b0, "add_sext"};
    vecs[10] = '{8'h33, 8'h44, 8'h20, 3'b101, 3'b000, 8'h33, 1'b0, 1'b0, "b_sel_zero"};
    vecs[11] = '{8'h55, 8'h11, 8'h20, 3'b000, 3'b101, 8'h00, 1'b0, 1'b1, "op_zero"};
    vecs[12] = '{8'h7F, 8'h00, 8'h20, 3'b100, 3'b100, 8'h7F, 1'b0, 1'b0, "shr0"};

    // Reset state
    cw    = '0;
    reset = 1'b1;
    #12;
    chk("rst_pc",    pc_out,    8'h00);
    chk("rst_ir",    ir_out,    8'h00);
    chk("rst_instr", 8'(instr), 8'h00);
    chk("rst_nz",    {6'b0, N, Z}, 8'h00);
    chk("rst_addr",  mem_addr,  8'h00);
    chk("rst_wdata", mem_wdata, 8'h00);
    reset = 1'b0;
    pc_m  = 8'h00;
    r0_m  = 8'h00;

    // Fetch: IR gets mem[PC] while PC increments on the same edge
    mem[0]     = 8'h64;
    cw         = '0;
    cw.pcwrite = 1'b1;
    cw.memread = 1'b1;
    cw.irload  = 1'b1;
    cw.alu2    = 3'b001;
    #1;
    chk("fetch_addr", mem_addr, 8'h00);
    chk("fetch_re",   8'(mem_re), 8'h01);
    chk("fetch_we",   8'(mem_we), 8'h00);
    tick();
    pc_m = 8'h01;
    chk("fetch_pc",    pc_out,    8'h01);
    chk("fetch_ir",    ir_out,    8'h64);
    chk("fetch_instr", 8'(instr), 8'h04);

    // Read-before-write on register 1
    load_reg(2'd1, 8'h11);
    mem[0]     = 8'h99;
    cw         = '0;
    cw.mdrload = 1'b1;
    tick();
    set_ir(8'h50);
    cw          = '0;
    cw.rfwrite  = 1'b1;
    cw.regin    = 1'b1;
    cw.r1r2load = 1'b1;
    tick();
    chk("rbw_r1", mem_wdata, 8'h11);
    chk("rbw_r2", mem_addr,  8'h11);
    read_reg(2'd1, 8'h99, "rbw_new");

    // ALU vectors: r1=a, r2=b, result written back to r1 via ALUOut
    for (int i = 0; i < 13; i++) begin
      do_reset();
      load_reg(2'd1, vecs[i].a);
      load_reg(2'd2, vecs[i].b);
      set_ir(vecs[i].ir);
      cw = '0;
      cw.r1sel    = 1'b1;
      cw.r1r2load = 1'b1;
      tick();
      cw = '0;
      cw.alu1        = 1'b1;
      cw.alu2        = vecs[i].alu2;
      cw.aluop       = vecs[i].aluop;
      cw.aluoutwrite = 1'b1;
      cw.flagwrite   = 1'b1;
      tick();
      cw = '0;
      cw.r1sel   = 1'b1;
      cw.rfwrite = 1'b1;
      tick();
      chk({vecs[i].name, "_n"}, 8'(N), 8'(vecs[i].n));
      chk({vecs[i].name, "_z"}, 8'(Z), 8'(vecs[i].z));
      read_reg(2'd1, vecs[i].res, {vecs[i].name, "_res"});
    end

    // Store r3 to address in r0, then load it back into r1
    do_reset();
    load_reg(2'd3, 8'h5A);
    load_reg(2'd0, 8'h20);
    set_ir(8'hC0);
    cw = '0;
    cw.r1r2load = 1'b1;
    tick();
    mem[8'h20]  = 8'h00;
    cw          = '0;
    cw.memwrite = 1'b1;
    #1;
    chk("st_we",    8'(mem_we), 8'h01);
    chk("st_addr",  mem_addr,   8'h20);
    chk("st_wdata", mem_wdata,  8'h5A);
    tick();
    chk("st_mem", mem[8'h20], 8'h5A);
    set_ir(8'h40);
    cw = '0;
    cw.r1r2load = 1'b1;
    tick();
    cw = '0;
    cw.memread = 1'b1;
    cw.mdrload = 1'b1;
    tick();
    cw = '0;
    cw.rfwrite = 1'b1;
    cw.regin   = 1'b1;
    tick();
    read_reg(2'd1, 8'h5A, "ld_r1");

    // Branch taken: PC=5 after fetching 0xE5, Z=1 -> PC=3
    do_reset();
    cw = '0;
    cw.alu1      = 1'b1;
    cw.alu2      = 3'b101;
    cw.flagwrite = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) set_ir(8'h00);
    set_ir(8'hE5);
    chk("br_pc_pre", pc_out, 8'h05);
    chk("br_z",      8'(Z),  8'h01);
    cw = '0;
    cw.alu2    = 3'b010;
    cw.pcwrite = 1'b1;
    tick();
    chk("br_pc", pc_out, 8'h03);
    pc_m = 8'h03;

    // PC wrap: force PC=0xFF via R1, then fetch
    load_reg(2'd1, 8'hFF);
    cw = '0;
    cw.r1sel    = 1'b1;
    cw.r1r2load = 1'b1;
    tick();
    cw = '0;
    cw.alu1    = 1'b1;
    cw.alu2    = 3'b101;
    cw.pcwrite = 1'b1;
    tick();
    chk("wrap_pc_ff", pc_out, 8'hFF);
    pc_m = 8'hFF;
    set_ir(8'h00);
    chk("wrap_pc_00", pc_out, 8'h00);

    // Asynchronous reset in the middle of a cycle
    set_ir(8'hC5);
    cw = '0;
    cw.alu2      = 3'b010;
    cw.flagwrite = 1'b1;
    tick();
    cw = '0;
    chk("mid_pre_n",     8'(N),     8'h01);
    chk("mid_pre_wdata", mem_wdata, 8'hFF);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_pc",    pc_out,    8'h00);
    chk("mid_ir",    ir_out,    8'h00);
    chk("mid_instr", 8'(instr), 8'h00);
    chk("mid_nz",    {6'b0, N, Z}, 8'h00);
    chk("mid_addr",  mem_addr,  8'h00);
    chk("mid_wdata", mem_wdata, 8'h00);
    #2;
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- 8-bit multicycle datapath driven by the processor's control-unit FSM.
- Holds PC, IR, MDR, R1/R2 operand latches, ALUOut, a 4x8 register file, the ALU and the N/Z flag register.
- Each cycle it executes whatever control word the FSM presents.
- It feeds back instr (IR[3:0]), N and Z to the FSM and drives an external asynchronous-read memory.

Parameters:
- WIDTH, 8, data/address width; must be 8 (instruction field extraction assumes 8).
- NREGS, 4, register-file depth; fixed by 2-bit register fields.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clock clock.
- PCwrite  in  1  load PC from ALU result.
- MemRead  in  1  memory read request; passed to mem_re.
- MemWrite  in  1  memory write strobe; passed to mem_we.
- IRload  in  1  load IR from mem_rdata; also selects PC as memory address.
- R1Sel  in  1  force register index 1 for R1 read/write (ORI).
- MDRload  in  1  load MDR from mem_rdata.
- R1R2Load  in  1  latch RF read ports into R1/R2 registers.
- ALU1  in  1  ALU A select: 0=PC, 1=R1 register.
- ALU2  in  3  ALU B select (see Behaviour).
- ALUop  in  3  ALU operation (see Behaviour).
- ALUOutWrite  in  1  load ALUOut from ALU result.
- RFWrite  in  1  write register file.
- RegIn  in  1  RF write data: 0=ALUOut, 1=MDR.
- FlagWrite  in  1  load N/Z from ALU result.
- mem_rdata  in  8  memory read data, combinational from mem_addr.
- mem_addr  out  8  IRload ? PC : R2 register.
- mem_wdata  out  8  R1 register.
- mem_we  out  1  = MemWrite.
- mem_re  out  1  = MemRead.
- instr  out  4  IR[3:0] to FSM.
- N  out  1  negative flag.
- Z  out  1  zero flag.
- pc_out  out  8  current PC (debug).
- ir_out  out  8  current IR (debug).

Behaviour:
- Reset (async, immediate):
  - PC, IR, MDR, R1, R2, ALUOut, all RF entries, N and Z clear to 0.
  - instr=0, pc_out=0, ir_out=0, mem_addr=0, mem_wdata=0.
  - Reset mid-instruction discards all partial state.
- Field decode:
  - Ra=IR[7:6], Rb=IR[5:4].
  - imm4=IR[7:4], signed (branch offset).
  - imm5=IR[7:3], unsigned (ORI).
  - shamt field=IR[5:3]: IR[5]=direction (1=right), IR[4:3]=amount 0..3.
- Register read indices: rd1 = R1Sel ? 1 : Ra; rd2 = Rb. Read is combinational.
- R1R2Load: R1<=RF[rd1], R2<=RF[rd2].
- RFWrite:
  - Write index = R1Sel ? 1 : Ra.
  - Write data = RegIn ? MDR : ALUOut.
- Simultaneous RFWrite and R1R2Load on the same index: R1/R2 capture the old value (read-before-write).
- ALU A = ALU1 ? R1 : PC.
- ALU B by ALU2:
  - 000 R2.
  - 001 constant 1.
  - 010 sign-extended imm4.
  - 011 zero-extended imm5.
  - 100 zero-extended IR[5:3].
  - 101-111 give 0.
- ALUop:
  - 000 A+B.
  - 001 A-B.
  - 010 A|B.
  - 011 ~(A&B).
  - 100 logical shift of A by B[1:0], right if B[2] else left.
  - 101-111 give 0.
- Arithmetic is mod 256 (carry/overflow discarded). PC 255+1 wraps to 0.
- Flags: on FlagWrite, N<=result[7] and Z<=(result==0). Otherwise flags hold.
- Register loads:
  - PCwrite: PC<=ALU result.
  - IRload: IR<=mem_rdata.
  - MDRload: MDR<=mem_rdata.
  - ALUOutWrite: ALUOut<=ALU result.
- All loads are independent and may coincide. All use pre-edge values (e.g. fetch: IR gets mem[PC] while PC gets PC+1 on the same edge).
- Store: mem_we=1 with mem_addr=R2, mem_wdata=R1 in the same cycle. The write itself occurs in memory at the edge.
- Branch: the FSM presents ALU1=0, ALU2=010, add, and conditional PCwrite. Target = (already incremented PC) + sext(imm4).
- No internal FSM. Latency is exactly one edge per control word. Outputs instr/N/Z are registered values only.

Test Plan:
- Reset then fetch: mem[0]=0x64 (add r1,r2); apply one fetch cycle (PCwrite, MemRead, IRload, ALU2=001) -> PC=1, IR=0x64, instr=0100, mem_addr was 0.
- ADD: preload r1=0x70, r2=0x90 via load sequences; run decode, ALU1=1 ALU2=000 ALUop=000 ALUOutWrite FlagWrite, then RFWrite -> r1=0x00, Z=1, N=0.
- ORI: r1=0x80, IR=0xFF (imm5=31); run R1Sel+R1R2Load, ALU2=011 ALUop=010, R1Sel+RFWrite -> r1=0x9F, N=1, Z=0; r3 unchanged.
- Shift: r2=0x81, IR=0xAB (Ra=2, right, amt 1) -> r2=0x40, N=0. IR=0x8B (left 1) on 0x81 -> 0x02.
- Load/store: store r3=0x5A to address in r0=0x20 -> mem_we=1, mem_addr=0x20, mem_wdata=0x5A; then load back into r1 (MDRload, RegIn=1) -> r1=0x5A.
- Branch with reset: PC=0x05, IR=0xE5 (imm4=-2), Z=1, bz control word -> PC=0x03. PC=0xFF after fetch -> 0x00. Assert reset mid-cycle -> all outputs 0 immediately.
